mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles spent in REQ without dmem_ack before timeout.
REQ-002 Port clk input 1: single clock; all state updates on its rising edge.
REQ-003 Port rst input 1: asynchronous, active-low reset (asserts when 0).
REQ-004 Port EX_MEM_MemRead input 1: load pending in MEM stage.
REQ-005 Port EX_MEM_MemWrite input 1: store pending in MEM stage.
REQ-006 Port EX_MEM_alu_result input 32: byte address of the access.
REQ-007 Port EX_MEM_store_data input 32: store source; data in low bits.
REQ-008 Port EX_MEM_size input 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Port EX_MEM_unsigned input 1: 1 zero-extends loads, 0 sign-extends loads.
REQ-010 Port memread_data output 32: aligned, extended load result presented to MEM/WB.
REQ-011 Port mem_stall output 1: freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while 1.
REQ-012 Port dmem_req output 1: request valid to data memory.
REQ-013 Port dmem_we output 1: 1 write, 0 read.
REQ-014 Port dmem_addr output 32: word address; EX_MEM_alu_result with bits [1:0] forced to 0.
REQ-015 Port dmem_wdata output 32: lane-replicated store data.
REQ-016 Port dmem_be output 4: byte enables.
REQ-017 Port dmem_ack input 1: memory completed the request this cycle.
REQ-018 Port dmem_rdata input 32: read word; valid only with dmem_ack.
REQ-019 Port misalign_err output 1: one-cycle pulse for a misaligned or reserved-size access.
REQ-020 Port timeout_err output 1: one-cycle pulse when MAX_WAIT expires.

Function
REQ-021 FSM states: IDLE, REQ, DONE; access = MemRead|MemWrite; MemRead and MemWrite both 1 is treated as a store.
REQ-022 IDLE, access, aligned -> REQ; mem_stall=1 combinationally in that same IDLE cycle.
REQ-023 Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00; size 11 never aligned.
REQ-024 IDLE, access, misaligned: no request, misalign_err=1 for the single cycle the access sits in IDLE, mem_stall=0, memread_data unchanged, stay IDLE.
REQ-025 REQ: dmem_req=1 with addr/we/be/wdata held constant; mem_stall=1; wait counter increments each cycle.
REQ-026 REQ with dmem_ack=1 -> DONE; for loads, memread_data registers extracted dmem_rdata at that edge.
REQ-027 REQ with counter = MAX_WAIT-1 and no ack -> DONE; timeout_err pulses on entry to DONE; load result registers as 0.
REQ-028 DONE: dmem_req=0, mem_stall=0 (pipeline advances on this edge), unconditional -> IDLE; counter cleared.
REQ-029 Minimum aligned-access latency: 3 cycles (IDLE, REQ with ack, DONE); mem_stall high 2 cycles.
REQ-030 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-031 Write data: byte replicated to 4 lanes; half replicated to 2 lanes; word unchanged.
REQ-032 Load extraction: byte lane addr[1:0], half lane addr[1]; extend per EX_MEM_unsigned.
REQ-033 dmem_ack outside REQ is ignored; memread_data holds between loads; stores never modify it.

Reset
REQ-034 rst low asynchronously forces IDLE, counter 0, memread_data 0, misalign_err 0, timeout_err 0, and dmem_req 0 in the same cycle, including mid-REQ; an in-flight access is abandoned.
REQ-035 First possible request is the first rising edge after rst returns high.

Structure
REQ-036 Shared package holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, and the MAX_WAIT default.
REQ-037 Sub-module mem_load_align: combinational lane select and extension; mem_access_unit instantiates it once.

Verification
REQ-038 LW addr 0x100, ack in 1st REQ cycle, rdata 0x12345678 -> dmem_addr 0x100, be 1111, stall 2 cycles, memread_data 0x12345678 in DONE.
REQ-039 LB signed addr 0x103, rdata 0x80FF_FF7F -> memread_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SH addr 0x102, store_data 0x0000ABCD -> we 1, be 1100, wdata 0xABCDABCD; memread_data unchanged.
REQ-041 LW addr 0x101 -> no dmem_req, misalign_err 1 cycle, mem_stall 0.
REQ-042 LW with ack held 0, MAX_WAIT 15 -> req 15 cycles, timeout_err pulse, memread_data 0, return to IDLE.
REQ-043 rst driven low in 3rd REQ cycle -> dmem_req and mem_stall 0 immediately; after release, new LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the MEM-stage data-memory access unit:
//               access-size encodings, FSM state enum, default wait limit and
//               small helpers for alignment, byte enables and lane replication.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Access size encodings carried on EX_MEM_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Default number of REQ cycles allowed before the access is abandoned
  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The reserved size is never aligned, so it always reports misalignment.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << addr_lo;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across every lane so the byte enables alone
  // pick the destination bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] data);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load-data lane select and sign/zero extension.
// Ports       : rdata_i    - raw 32-bit word returned by data memory
//               addr_lo_i  - byte offset (address bits [1:0]) of the load
//               size_i     - access size encoding
//               unsigned_i - 1 zero-extends, 0 sign-extends
//               data_o     - aligned, extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_ext;
  logic        w_half_ext;

  always_comb begin
    w_byte     = rdata_i[{addr_lo_i, 3'b000} +: 8];
    // Halfwords are aligned, so only address bit 1 selects the lane.
    w_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    w_byte_ext = ~unsigned_i & w_byte[7];
    w_half_ext = ~unsigned_i & w_half[15];
    case (size_i)
      SZ_BYTE: data_o = {{24{w_byte_ext}}, w_byte};
      SZ_HALF: data_o = {{16{w_half_ext}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit. Launches one data-memory request
//               per aligned access, stalls the pipeline until the memory
//               acknowledges (or the wait limit expires), and returns the
//               aligned, extended load result.
// Ports       : clk, rst (async, active-low)
//               EX_MEM_* - access from the EX/MEM register
//               memread_data, mem_stall - results/stall toward the pipeline
//               dmem_*   - data memory request/response
//               misalign_err, timeout_err - single-cycle error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_store_data,
  input  logic [1:0]  EX_MEM_size,
  input  logic        EX_MEM_unsigned,
  output logic [31:0] memread_data,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int              CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               we_q, we_d;
  logic [1:0]         lo_q, lo_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        memread_q, memread_d;
  logic               timeout_q, timeout_d;

  logic               w_access;
  logic               w_aligned;
  logic [31:0]        w_load_data;

  assign w_access  = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign w_aligned = is_aligned(EX_MEM_size, EX_MEM_alu_result[1:0]);

  // Extraction works from the captured request attributes, since the
  // response arrives while the REQ state holds them.
  mem_load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .addr_lo_i  (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (w_load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      lo_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      memread_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      memread_q <= memread_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    lo_d         = lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    memread_d    = memread_q;
    timeout_d    = 1'b0;
    mem_stall    = 1'b0;
    misalign_err = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (w_access) begin
          if (w_aligned) begin
            state_d = REQ;
            // Combinational outputs are qualified with rst so a held access
            // cannot stall or flag an error while reset is asserted.
            mem_stall = rst;
            addr_d    = {EX_MEM_alu_result[31:2], 2'b00};
            wdata_d   = store_lanes(EX_MEM_size, EX_MEM_store_data);
            be_d      = byte_en(EX_MEM_size, EX_MEM_alu_result[1:0]);
            we_d      = EX_MEM_MemWrite;  // read+write together is a store
            lo_d      = EX_MEM_alu_result[1:0];
            size_d    = EX_MEM_size;
            uns_d     = EX_MEM_unsigned;
          end else begin
            misalign_err = rst;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d = DONE;
          if (!we_q) memread_d = w_load_data;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          if (!we_q) memread_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign memread_data = memread_q;
  assign timeout_err  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit. The stimulus process
//               issues directed accesses and queues hand-computed expected
//               requests, completions and misalignment events; a monitor on
//               the falling edge pops and compares whenever the DUT shows one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] mrd;
    logic        to;
    int          stall;
    int          reqc;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Uns;
  logic [31:0] Addr, SData;
  logic [1:0]  Size;
  logic [31:0] memread_data;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        misalign_err, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] err_q[$];
  logic [31:0] exp_mrd = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_MemRead    (MemRead),
    .EX_MEM_MemWrite   (MemWrite),
    .EX_MEM_alu_result (Addr),
    .EX_MEM_store_data (SData),
    .EX_MEM_size       (Size),
    .EX_MEM_unsigned   (Uns),
    .memread_data      (memread_data),
    .mem_stall         (mem_stall),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .misalign_err      (misalign_err),
    .timeout_err       (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic  prev_req = 1'b0;
  logic  prev_stall = 1'b0;
  int    stall_cnt = 0;
  int    req_cnt = 0;
  req_t  m_req;
  done_t m_done;
  logic [31:0] m_err;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_req   = 1'b0;
      prev_stall = 1'b0;
      stall_cnt  = 0;
      req_cnt    = 0;
    end else begin
      if (mem_stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected request", 32'd1, 32'd0);
        else begin
          m_req = req_q.pop_front();
          chk("dmem_addr", dmem_addr, m_req.addr);
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_req.we});
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, m_req.be});
          chk("dmem_wdata", dmem_wdata, m_req.wdata);
        end
      end
      if (misalign_err) begin
        if (err_q.size() == 0) chk("unexpected misalign_err", 32'd1, 32'd0);
        else begin
          m_err = err_q.pop_front();
          chk("misalign mem_stall", {31'd0, mem_stall}, 32'd0);
          chk("misalign dmem_req", {31'd0, dmem_req}, 32'd0);
          chk("misalign memread_data", memread_data, m_err);
        end
      end
      if (!mem_stall && prev_stall && prev_req) begin
        if (done_q.size() == 0) chk("unexpected completion", 32'd1, 32'd0);
        else begin
          m_done = done_q.pop_front();
          chk("memread_data", memread_data, m_done.mrd);
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_done.to});
          chk("stall cycles", stall_cnt, m_done.stall);
          chk("req cycles", req_cnt, m_done.reqc);
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end
      prev_req   = dmem_req;
      prev_stall = mem_stall;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_access();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 32'h0;
    SData    = 32'h0;
    Size     = 2'b00;
    Uns      = 1'b0;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns the same way.
  // ack_dly = REQ cycle index carrying the ack, -1 for no ack at all.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] sd, input logic [1:0] sz, input logic u,
                        input int ack_dly, input logic [31:0] rdat,
                        input req_t er, input done_t ed);
    int  n;
    logic fin;
    MemRead = rd; MemWrite = wr; Addr = a; SData = sd; Size = sz; Uns = u;
    req_q.push_back(er);
    done_q.push_back(ed);
    exp_mrd = ed.mrd;
    @(posedge clk); #1;
    n = 0; fin = 1'b0;
    while (!fin && n < 40) begin
      if (ack_dly == n) begin dmem_ack = 1'b1; dmem_rdata = rdat; end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
      if (!dmem_req) fin = 1'b1;
      n++;
    end
    if (!fin) chk("REQ wait bound", 32'd1, 32'd0);
    clear_access();
    @(posedge clk); #1;
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [1:0] sz);
    MemRead = rd; MemWrite = wr; Addr = a; SData = 32'h1111_2222; Size = sz; Uns = 1'b0;
    err_q.push_back(exp_mrd);
    @(posedge clk); #1;
    clear_access();
  endtask

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    clear_access();
    repeat (2) @(negedge clk);
    chk("reset memread_data", memread_data, 32'h0);
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("reset misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("reset timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // LW 0x100, ack in first REQ cycle
    access(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, 32'h1234_5678,
           '{addr:32'h100, we:1'b0, be:4'b1111, wdata:32'h0},
           '{mrd:32'h1234_5678, to:1'b0, stall:2, reqc:1});
    // LB signed / LBU at 0x103
    access(1, 0, 32'h103, 32'h0, 2'b00, 0, 0, 32'h80FF_FF7F,
           '{addr:32'h100, we:1'b0, be:4'b1000, wdata:32'h0},
           '{mrd:32'hFFFF_FF80, to:1'b0, stall:2, reqc:1});
    access(1, 0, 32'h103, 32'h0, 2'b00, 1, 0, 32'h80FF_FF7F,
           '{addr:32'h100, we:1'b0, be:4'b1000, wdata:32'h0},
           '{mrd:32'h0000_0080, to:1'b0, stall:2, reqc:1});
    // SH 0x102: lanes replicated, load result untouched
    access(0, 1, 32'h102, 32'h0000_ABCD, 2'b01, 0, 0, 32'hFFFF_FFFF,
           '{addr:32'h100, we:1'b1, be:4'b1100, wdata:32'hABCD_ABCD},
           '{mrd:32'h0000_0080, to:1'b0, stall:2, reqc:1});
    // misaligned word, reserved size, misaligned half
    misaligned(1, 0, 32'h101, 2'b10);
    misaligned(1, 0, 32'h000, 2'b11);
    misaligned(1, 0, 32'h103, 2'b01);
    // LH signed upper lane, ack in third REQ cycle
    access(1, 0, 32'h206, 32'h0, 2'b01, 0, 2, 32'h8001_7FFF,
           '{addr:32'h204, we:1'b0, be:4'b1100, wdata:32'h0},
           '{mrd:32'hFFFF_8001, to:1'b0, stall:4, reqc:3});
    // SB 0x305
    access(0, 1, 32'h305, 32'h1234_56A5, 2'b00, 0, 0, 32'h0,
           '{addr:32'h304, we:1'b1, be:4'b0010, wdata:32'hA5A5_A5A5},
           '{mrd:32'hFFFF_8001, to:1'b0, stall:2, reqc:1});
    // read and write together behave as a store
    access(1, 1, 32'h040, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h7777_7777,
           '{addr:32'h040, we:1'b1, be:4'b1111, wdata:32'hCAFE_F00D},
           '{mrd:32'hFFFF_8001, to:1'b0, stall:2, reqc:1});
    // LHU lower lane
    access(1, 0, 32'h000, 32'h0, 2'b01, 1, 0, 32'h1234_F00D,
           '{addr:32'h000, we:1'b0, be:4'b0011, wdata:32'h0},
           '{mrd:32'h0000_F00D, to:1'b0, stall:2, reqc:1});

    // ack while idle is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("idle ack ignored", memread_data, 32'h0000_F00D);

    // LW never acknowledged: 15 REQ cycles then timeout, result 0
    access(1, 0, 32'h500, 32'h0, 2'b10, 0, -1, 32'h0,
           '{addr:32'h500, we:1'b0, be:4'b1111, wdata:32'h0},
           '{mrd:32'h0, to:1'b1, stall:16, reqc:15});
    // LW with ack in second REQ cycle
    access(1, 0, 32'h700, 32'h0, 2'b10, 0, 1, 32'hA5A5_0F0F,
           '{addr:32'h700, we:1'b0, be:4'b1111, wdata:32'h0},
           '{mrd:32'hA5A5_0F0F, to:1'b0, stall:3, reqc:2});

    // reset in the third REQ cycle abandons the access
    MemRead = 1'b1; Addr = 32'h600; Size = 2'b10;
    req_q.push_back('{addr:32'h600, we:1'b0, be:4'b1111, wdata:32'h0});
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("abort dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("abort mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("abort memread_data", memread_data, 32'h0);
    chk("abort timeout_err", {31'd0, timeout_err}, 32'd0);
    exp_mrd = 32'h0;
    clear_access();
    @(posedge clk); #1;
    rst = 1'b1;
    access(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, 32'h0BAD_CAFE,
           '{addr:32'h100, we:1'b0, be:4'b1111, wdata:32'h0},
           '{mrd:32'h0BAD_CAFE, to:1'b0, stall:2, reqc:1});

    repeat (4) @(posedge clk);
    chk("pending requests", req_q.size(), 32'd0);
    chk("pending completions", done_q.size(), 32'd0);
    chk("pending misalign events", err_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
